// File: rtl/regfile_pkg.sv
// Shared widths and grant index type for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; prio names the requester that wins a tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  grant_e prio;

  // Tie goes to prio; no grant at all while reset is held.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (req[0] && (!req[1] || prio == GRANT_REQ0)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= GRANT_REQ0;
    end else if (advance) begin
      prio <= gnt[0] ? GRANT_REQ1 : GRANT_REQ0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for two requesters plus a pending-write scoreboard
// providing read-after-write hazard flags.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_reserve_valid,
  input  logic [ADDR_WIDTH-1:0]       in_reserve_address,
  input  logic                        in_req0_valid,
  input  logic [ADDR_WIDTH-1:0]       in_req0_address,
  input  logic [DATA_WIDTH-1:0]       in_req0_data,
  input  logic                        in_req1_valid,
  input  logic [ADDR_WIDTH-1:0]       in_req1_address,
  input  logic [DATA_WIDTH-1:0]       in_req1_data,
  output logic                        out_req0_ready,
  output logic                        out_req1_ready,
  input  logic [ADDR_WIDTH-1:0]       in_read1_address,
  input  logic [ADDR_WIDTH-1:0]       in_read2_address,
  output logic                        out_read1_hazard,
  output logic                        out_read2_hazard,
  output logic                        out_write_enable,
  output logic [ADDR_WIDTH-1:0]       out_write_address,
  output logic [DATA_WIDTH-1:0]       out_write_data,
  output logic [(2**ADDR_WIDTH)-1:0]  out_pending
);

  logic [1:0]            gnt;
  logic                  transfer;
  grant_e                sel;
  logic [ADDR_WIDTH-1:0] wb_address;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [(2**ADDR_WIDTH)-1:0] pending_next;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({in_req1_valid, in_req0_valid}),
    .advance (transfer),
    .gnt     (gnt)
  );

  assign out_req0_ready = gnt[0];
  assign out_req1_ready = gnt[1];
  assign transfer       = |gnt;

  always_comb begin
    sel        = GRANT_REQ0;
    wb_address = in_req0_address;
    wb_data    = in_req0_data;
    if (gnt[1]) begin
      sel = GRANT_REQ1;
    end
    if (sel == GRANT_REQ1) begin
      wb_address = in_req1_address;
      wb_data    = in_req1_data;
    end
  end

  // Register-file write port; x0 transfers are accepted but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_write_enable  <= 1'b0;
      out_write_address <= '0;
      out_write_data    <= '0;
    end else begin
      out_write_enable <= transfer && (wb_address != '0);
      if (transfer) begin
        out_write_address <= wb_address;
        out_write_data    <= wb_data;
      end
    end
  end

  // Clear on commit first so a same-cycle reservation wins.
  always_comb begin
    pending_next = out_pending;
    if (out_write_enable) begin
      pending_next[out_write_address] = 1'b0;
    end
    if (in_reserve_valid && (in_reserve_address != '0)) begin
      pending_next[in_reserve_address] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pending <= '0;
    end else begin
      out_pending <= pending_next;
    end
  end

  assign out_read1_hazard = (in_read1_address != '0) && out_pending[in_read1_address];
  assign out_read2_hazard = (in_read2_address != '0) && out_pending[in_read2_address];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized plus directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv;
  logic [4:0]  ra;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1;
  logic [4:0]  rd1, rd2;
  logic        hz1, hz2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pend;

  // Reference state: who wins a tie, pending registers, expected write port.
  int          m_tie;
  bit [31:0]   m_pend;
  bit          m_we;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .in_reserve_valid   (rv),
    .in_reserve_address (ra),
    .in_req0_valid      (v0),
    .in_req0_address    (a0),
    .in_req0_data       (d0),
    .in_req1_valid      (v1),
    .in_req1_address    (a1),
    .in_req1_data       (d1),
    .out_req0_ready     (rdy0),
    .out_req1_ready     (rdy1),
    .in_read1_address   (rd1),
    .in_read2_address   (rd2),
    .out_read1_hazard   (hz1),
    .out_read2_hazard   (hz2),
    .out_write_enable   (we),
    .out_write_address  (wa),
    .out_write_data     (wd),
    .out_pending        (pend)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int winner();
    if (reset) return -1;
    if (v0 && v1) return m_tie;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Compare every observable output with the model for the current inputs.
  task automatic compare();
    int w;
    #1;
    w = winner();
    chk("ready0", 64'(rdy0), 64'(w == 0));
    chk("ready1", 64'(rdy1), 64'(w == 1));
    chk("hazard1", 64'(hz1), 64'(rd1 != 0 && m_pend[rd1]));
    chk("hazard2", 64'(hz2), 64'(rd2 != 0 && m_pend[rd2]));
    chk("write_enable", 64'(we), 64'(m_we));
    chk("pending", 64'(pend), 64'(m_pend));
    if (m_we) begin
      chk("write_address", 64'(wa), 64'(m_wa));
      chk("write_data", 64'(wd), 64'(m_wd));
    end
  endtask

  // Clock edge: apply the rules to the model, then return to the falling edge.
  task automatic advance();
    int w;
    w = winner();
    @(posedge clk);
    if (reset) begin
      m_tie = 0; m_pend = '0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      if (m_we) m_pend[m_wa] = 1'b0;
      if (rv && ra != 0) m_pend[ra] = 1'b1;
      m_we = 0;
      if (w >= 0) begin
        m_wa  = (w == 0) ? a0 : a1;
        m_wd  = (w == 0) ? d0 : d1;
        m_we  = (m_wa != 0);
        m_tie = 1 - w;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; rv = 0; ra = '0; v0 = 0; v1 = 0; a0 = '0; a1 = '0;
    d0 = '0; d1 = '0; rd1 = '0; rd2 = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    compare(); advance();
    compare(); advance();
    reset = 0;
  endtask

  initial begin
    idle(); reset = 1;
    m_tie = 0; m_pend = '0; m_we = 0; m_wa = '0; m_wd = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    compare();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_wd", 64'(wd), 64'd0);
    chk("rst_pending", 64'(pend), 64'd0);

    // Single requester
    v0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    compare(); chk("single_ready0", 64'(rdy0), 64'd1);
    advance(); idle();
    compare();
    chk("single_we", 64'(we), 64'd1);
    chk("single_wa", 64'(wa), 64'd5);
    chk("single_wd", 64'(wd), 64'hDEADBEEF);
    advance();

    // Contention after reset: grants alternate starting with requester 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v0 = 1; a0 = 5'd1; d0 = 32'(100 + k);
      v1 = 1; a1 = 5'd2; d1 = 32'(200 + k);
      compare();
      chk("cont_ready0", 64'(rdy0), 64'((k % 2) == 0));
      chk("cont_ready1", 64'(rdy1), 64'((k % 2) == 1));
      if (k > 0) chk("cont_wa", 64'(wa), 64'((k % 2) == 1 ? 1 : 2));
      advance();
    end
    idle(); compare();
    chk("cont_last_wa", 64'(wa), 64'd2);
    advance();

    // Scoreboard: reserve 7, hazard until the commit cycle ends
    rv = 1; ra = 5'd7; compare(); advance(); idle();
    rd1 = 5'd7; compare();
    chk("sb_hazard_set", 64'(hz1), 64'd1);
    v0 = 1; a0 = 5'd7; d0 = 32'h77;
    compare(); advance(); idle(); rd1 = 5'd7;
    compare();
    chk("sb_we", 64'(we), 64'd1);
    chk("sb_hazard_commit", 64'(hz1), 64'd1);
    advance(); rd1 = 5'd7;
    compare();
    chk("sb_hazard_clear", 64'(hz1), 64'd0);
    chk("sb_pending7", 64'(pend[7]), 64'd0);
    advance();

    // Collision: reservation and commit of register 9 in the same cycle
    rv = 1; ra = 5'd9; compare(); advance(); idle();
    v1 = 1; a1 = 5'd9; d1 = 32'h99; compare(); advance(); idle();
    rv = 1; ra = 5'd9; compare();
    chk("col_we", 64'(we), 64'd1);
    advance(); idle();
    compare();
    chk("col_pending9", 64'(pend[9]), 64'd1);

    // Register 0 is accepted but never written nor reserved
    v1 = 1; a1 = 5'd0; d1 = 32'h1234;
    compare(); chk("x0_ready1", 64'(rdy1), 64'd1);
    advance(); idle();
    compare(); chk("x0_we", 64'(we), 64'd0);
    rv = 1; ra = 5'd0; advance(); idle();
    rd1 = 5'd0; compare();
    chk("x0_pending0", 64'(pend[0]), 64'd0);
    chk("x0_hazard", 64'(hz1), 64'd0);
    advance();

    // Reset in the cycle following a transfer
    do_reset();
    rv = 1; ra = 5'd4;
    v1 = 1; a1 = 5'd3; d1 = 32'hCAFE;
    compare(); advance(); idle();
    reset = 1; v0 = 1; v1 = 1; a0 = 5'd6; a1 = 5'd8;
    compare();
    chk("mid_rst_ready0", 64'(rdy0), 64'd0);
    chk("mid_rst_ready1", 64'(rdy1), 64'd0);
    advance(); reset = 0;
    compare();
    chk("mid_rst_we", 64'(we), 64'd0);
    chk("mid_rst_pending", 64'(pend), 64'd0);
    chk("mid_rst_tie", 64'(rdy0), 64'd1);
    advance();

    // Randomized traffic over a small address range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 2) == 0);
      ra  = 5'($urandom_range(0, 9));
      v0  = ($urandom_range(0, 1) == 0);
      v1  = ($urandom_range(0, 1) == 0);
      a0  = 5'($urandom_range(0, 9));
      a1  = 5'($urandom_range(0, 9));
      d0  = $urandom;
      d1  = $urandom;
      rd1 = 5'($urandom_range(0, 9));
      rd2 = 5'($urandom_range(0, 31));
      compare();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
